// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched
//   Schedules up to NREQ write requesters onto the two write ports of the
//   register file. Up to two requests are granted per cycle in round-robin
//   order. Two grants in the same cycle never target the same address.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester write request (bit i = requester i)
//   req_addr      destination register, slice i = [i*AW +: AW]
//   req_data      write data, slice i = [i*DW +: DW]
//   req_ready     combinational grant; a request is accepted on valid&ready
//   write         registered write enables (bit0 = port 1, bit1 = port 2)
//   write_port_1  registered address for write port 1
//   write_port_2  registered address for write port 2
//   in1           registered data for write port 1
//   in2           registered data for write port 2
module regfile_wr_sched #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [1:0]         write,
  output logic [AW-1:0]      write_port_1,
  output logic [AW-1:0]      write_port_2,
  output logic [DW-1:0]      in1,
  output logic [DW-1:0]      in2
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] data_a [NREQ];

  logic          g1_found;
  logic          g2_found;
  logic [PW-1:0] g1_idx;
  logic [PW-1:0] g2_idx;
  logic [AW-1:0] g1_addr;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic [NREQ-1:0] grant;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*AW +: AW];
    assign data_a[i] = req_data[i*DW +: DW];
  end

  // Scan requesters starting at ptr. The first valid one is G1; the next
  // valid one whose address differs from G1 is G2. Same-address requesters
  // behind G1 are simply passed over this cycle.
  always_comb begin
    g1_found = 1'b0;
    g2_found = 1'b0;
    g1_idx   = '0;
    g2_idx   = '0;
    g1_addr  = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (req_valid[idx]) begin
        if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = idx;
          g1_addr  = addr_a[idx];
        end else if (!g2_found && (addr_a[idx] != g1_addr)) begin
          g2_found = 1'b1;
          g2_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (g1_found) grant[g1_idx] = 1'b1;
    if (g2_found) grant[g2_idx] = 1'b1;
  end

  // No handshakes may complete while reset is held.
  assign req_ready = rst_n ? grant : '0;

  // Pointer moves just past G1, so a requester skipped for an address
  // match gains priority on the following cycles.
  assign ptr_nxt = (g1_idx == PW'(NREQ-1)) ? '0 : g1_idx + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      write        <= '0;
      write_port_1 <= '0;
      write_port_2 <= '0;
      in1          <= '0;
      in2          <= '0;
    end else begin
      write <= {g2_found, g1_found};
      if (g1_found) begin
        ptr          <= ptr_nxt;
        write_port_1 <= g1_addr;
        in1          <= data_a[g1_idx];
      end
      if (g2_found) begin
        write_port_2 <= addr_a[g2_idx];
        in2          <= data_a[g2_idx];
      end
    end
  end

endmodule
